ex_muldiv_stage: RTL

Execute-stage operand and M-extension unit, directly downstream of the forwarding unit. It applies forwardA/forwardB selects to pick ALU operands and store data from the register-file, EX/MEM or MEM/WB values. It also executes RV32M multiply/divide ops on a multi-cycle sequencer, raising a stall request until the result is ready.

---
 rtl/ex_muldiv_stage_if.sv | 49 ++++
 rtl/ex_muldiv_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_stage_if.sv
// -----------------------------------------------------------------------------
// ex_muldiv_stage_if
// Bundles the EX-stage signals that the execute operand/M-extension stage
// exchanges with the rest of the pipeline.
//   master : pipeline side. It drives the ID/EX fields, forwarding selects and
//            forwarded values, and receives the operands, the stall request and
//            the M-op result.
//   slave  : ex_muldiv_stage side (mirror of master).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface ex_muldiv_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 6
) ();
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       ex_imm;
  logic                  ex_alu_src;
  logic [1:0]            forwardA;
  logic [1:0]            forwardB;
  logic [XLEN-1:0]       me_alu_result;
  logic [XLEN-1:0]       wb_write_data;
  logic                  ex_md_en;
  logic [2:0]            ex_md_op;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  flush;
  logic [XLEN-1:0]       op_a;
  logic [XLEN-1:0]       op_b;
  logic [XLEN-1:0]       store_data;
  logic                  md_busy;
  logic                  md_done;
  logic [XLEN-1:0]       md_result;
  logic [REG_ADDR_W-1:0] md_rd;

  modport master (
    output ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_src,
           forwardA, forwardB, me_alu_result, wb_write_data,
           ex_md_en, ex_md_op, ex_rd, flush,
    input  op_a, op_b, store_data, md_busy, md_done, md_result, md_rd
  );

  modport slave (
    input  ex_valid, ex_rs1_data, ex_rs2_data, ex_imm, ex_alu_src,
           forwardA, forwardB, me_alu_result, wb_write_data,
           ex_md_en, ex_md_op, ex_rd, flush,
    output op_a, op_b, store_data, md_busy, md_done, md_result, md_rd
  );
endinterface

// File: rtl/ex_muldiv_stage.sv
// -----------------------------------------------------------------------------
// ex_muldiv_stage
// Execute-stage operand selection plus an RV32M multiply/divide sequencer.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : ex_muldiv_stage_if.slave
//          inputs  - ID/EX operands, immediate, ALU source select, forwarding
//                    selects and forwarded EX/MEM and MEM/WB values, M-op
//                    enable/opcode/rd, flush
//          outputs - op_a/op_b/store_data (combinational), md_busy stall
//                    request (combinational), md_done/md_result/md_rd
//                    (registered)
// Multiplies take two cycles (start + product). Divides run a restoring
// divider one quotient bit per cycle. Division by zero and signed overflow
// finish directly from the start cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module ex_muldiv_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 6,
  parameter int DIV_CYCLES = 32
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_stage_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's complement negation.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t                state_r;
  state_t                next_state_s;

  logic [XLEN-1:0]       fwd_a_s;
  logic [XLEN-1:0]       fwd_b_s;

  // Captured operands. For divides, opa_r is the dividend that shifts out
  // into the remainder while quotient bits shift in; opb_r is the divisor.
  logic [XLEN-1:0]       opa_r;
  logic [XLEN-1:0]       opb_r;
  logic [XLEN-1:0]       rem_r;
  logic [2:0]            op_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic                  neg_fix_r;
  logic [CNT_W-1:0]      cnt_r;

  logic                  md_done_r;
  logic [XLEN-1:0]       md_result_r;
  logic [REG_ADDR_W-1:0] md_rd_r;

  logic                  start_s;
  logic                  is_div_s;
  logic                  is_rem_s;
  logic                  signed_div_s;
  logic                  div_zero_s;
  logic                  div_ovf_s;
  logic                  special_s;
  logic [XLEN-1:0]       special_result_s;
  logic                  a_neg_s;
  logic                  b_neg_s;
  logic [XLEN-1:0]       a_mag_s;
  logic [XLEN-1:0]       b_mag_s;

  logic [2*XLEN-1:0]     mul_a_ext_s;
  logic [2*XLEN-1:0]     mul_b_ext_s;
  logic [2*XLEN-1:0]     product_s;
  logic [XLEN-1:0]       mul_result_s;

  logic [XLEN:0]         rem_shift_s;
  logic [XLEN:0]         rem_diff_s;
  logic                  step_ok_s;
  logic [XLEN-1:0]       rem_next_s;
  logic [XLEN-1:0]       quo_next_s;
  logic [XLEN-1:0]       div_result_s;

  // Forwarding muxes; select 11 falls back to the ID/EX value.
  always_comb begin
    fwd_a_s = bus.ex_rs1_data;
    fwd_b_s = bus.ex_rs2_data;
    case (bus.forwardA)
      2'b10:   fwd_a_s = bus.me_alu_result;
      2'b01:   fwd_a_s = bus.wb_write_data;
      default: fwd_a_s = bus.ex_rs1_data;
    endcase
    case (bus.forwardB)
      2'b10:   fwd_b_s = bus.me_alu_result;
      2'b01:   fwd_b_s = bus.wb_write_data;
      default: fwd_b_s = bus.ex_rs2_data;
    endcase
  end

  assign bus.op_a       = fwd_a_s;
  assign bus.op_b       = bus.ex_alu_src ? bus.ex_imm : fwd_b_s;
  assign bus.store_data = fwd_b_s;

  // Start decode: a new M op is accepted only from IDLE. The stall request
  // includes the start cycle so the instruction holds in EX from cycle T on.
  always_comb begin
    start_s      = (state_r == ST_IDLE) && bus.ex_valid && bus.ex_md_en && !bus.flush;
    is_div_s     = bus.ex_md_op[2];
    is_rem_s     = bus.ex_md_op[2] && bus.ex_md_op[1];
    signed_div_s = (bus.ex_md_op == OP_DIV) || (bus.ex_md_op == OP_REM);
    div_zero_s   = (fwd_b_s == ZERO);
    div_ovf_s    = signed_div_s && (fwd_a_s == INT_MIN) && (fwd_b_s == ALL_ONES);
    special_s    = is_div_s && (div_zero_s || div_ovf_s);
    a_neg_s      = signed_div_s && fwd_a_s[XLEN-1];
    b_neg_s      = signed_div_s && fwd_b_s[XLEN-1];
    a_mag_s      = a_neg_s ? negate(fwd_a_s) : fwd_a_s;
    b_mag_s      = b_neg_s ? negate(fwd_b_s) : fwd_b_s;
    if (div_zero_s) begin
      special_result_s = is_rem_s ? fwd_a_s : ALL_ONES;
    end else begin
      special_result_s = is_rem_s ? ZERO : INT_MIN;
    end
  end

  assign bus.md_busy = start_s || (state_r == ST_MUL) || (state_r == ST_DIV);

  // Full-width product of the captured operands, sign-extended per opcode.
  always_comb begin
    mul_a_ext_s = {{XLEN{((op_r == OP_MULH) || (op_r == OP_MULHSU)) && opa_r[XLEN-1]}}, opa_r};
    mul_b_ext_s = {{XLEN{(op_r == OP_MULH) && opb_r[XLEN-1]}}, opb_r};
    product_s   = mul_a_ext_s * mul_b_ext_s;
    if (op_r == OP_MUL) begin
      mul_result_s = product_s[XLEN-1:0];
    end else begin
      mul_result_s = product_s[2*XLEN-1:XLEN];
    end
  end

  // One restoring-division step plus the sign fix-up of the final step.
  always_comb begin
    rem_shift_s = {rem_r, opa_r[XLEN-1]};
    rem_diff_s  = rem_shift_s - {1'b0, opb_r};
    step_ok_s   = !rem_diff_s[XLEN];
    if (step_ok_s) begin
      rem_next_s = rem_diff_s[XLEN-1:0];
    end else begin
      rem_next_s = rem_shift_s[XLEN-1:0];
    end
    quo_next_s = {opa_r[XLEN-2:0], step_ok_s};
    if (op_r[1]) begin
      div_result_s = neg_fix_r ? negate(rem_next_s) : rem_next_s;
    end else begin
      div_result_s = neg_fix_r ? negate(quo_next_s) : quo_next_s;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Sequencer next-state logic; flush aborts only while iterating.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!start_s) begin
          next_state_s = ST_IDLE;
        end else if (!is_div_s) begin
          next_state_s = ST_MUL;
        end else if (special_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DIV;
        end
      end
      ST_MUL: begin
        if (bus.flush) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      ST_DIV: begin
        if (bus.flush) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DIV;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Operand capture, divider iteration and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r       <= ZERO;
      opb_r       <= ZERO;
      rem_r       <= ZERO;
      op_r        <= 3'd0;
      rd_r        <= {REG_ADDR_W{1'b0}};
      neg_fix_r   <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      md_done_r   <= 1'b0;
      md_result_r <= ZERO;
      md_rd_r     <= {REG_ADDR_W{1'b0}};
    end else begin
      md_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            op_r  <= bus.ex_md_op;
            rd_r  <= bus.ex_rd;
            rem_r <= ZERO;
            cnt_r <= {CNT_W{1'b0}};
            if (is_div_s) begin
              // Iterate on magnitudes; remember the sign to restore at the end.
              opa_r     <= a_mag_s;
              opb_r     <= b_mag_s;
              neg_fix_r <= is_rem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
            end else begin
              opa_r     <= fwd_a_s;
              opb_r     <= fwd_b_s;
              neg_fix_r <= 1'b0;
            end
            if (special_s) begin
              md_result_r <= special_result_s;
              md_rd_r     <= bus.ex_rd;
              md_done_r   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (!bus.flush) begin
            md_result_r <= mul_result_s;
            md_rd_r     <= rd_r;
            md_done_r   <= 1'b1;
          end
        end
        ST_DIV: begin
          if (!bus.flush) begin
            rem_r <= rem_next_s;
            opa_r <= quo_next_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              md_result_r <= div_result_s;
              md_rd_r     <= rd_r;
              md_done_r   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          md_done_r <= 1'b0;
        end
        default: begin
          md_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.md_done   = md_done_r;
  assign bus.md_result = md_result_r;
  assign bus.md_rd     = md_rd_r;

endmodule
